menu_overlay: RTL and testbench
===============================

Name: menu_overlay

Overview:
- Pipelined HDMI menu-bar renderer: draws N_ITEMS bitmap labels (glyph strips from an external synchronous ROM) in one horizontal row over a solid background.
- Tracks a user selection cursor driven by key pulses; the selected item is drawn in blinking highlight colours.
- Sits between the timing generator (act_x/act_y, vs/hs/de) and the HDMI encoder, delaying sync signals to match pixel latency.

Parameters:
- X_BITS, 13, width of act_x
- Y_BITS, 13, width of act_y
- N_ITEMS, 3, number of labels (1..8)
- ITEM_W, 240, label width in pixels; equals ROM word width
- ITEM_H, 48, label height in rows
- X0, 75, left edge of item 0
- Y0, 300, top row of all items
- GAP, 75, horizontal pixels between items
- ADDR_W, 10, ROM address width (must hold N_ITEMS*ITEM_H)
- ROM_LAT, 1, ROM read latency in cycles (1 or 2)
- BLINK_FRAMES, 30, frames per highlight blink half-period
- FG, 16'hFFFF, glyph colour (RGB565); BG, 16'h0000, background colour
- HL_FG, 16'h0000 and HL_BG, 16'hFFE0, highlight glyph/background colours

Ports:
- pix_clk  in  1  pixel clock
- rst  in  1  synchronous reset, active-high
- act_x  in  X_BITS  active-area x of current pixel
- act_y  in  Y_BITS  active-area y of current pixel
- vs_in, hs_in, de_in  in  1 each  timing from generator
- key_left, key_right, key_ok  in  1 each  single-cycle debounced key pulses
- rom_addr  out  ADDR_W  glyph ROM row address
- rom_data  in  ITEM_W  glyph row, bit ITEM_W-1 = leftmost pixel
- vs_out, hs_out, de_out  out  1 each  timing delayed by L
- rgb_data  out  16  RGB565 pixel, aligned with de_out
- sel_idx  out  $clog2(N_ITEMS) (min 1)  committed selection
- sel_confirm  out  1  one-cycle pulse on confirm

Behaviour:
- Latency L = 2 + ROM_LAT cycles from act_x/act_y/syncs to rgb_data/syncs out. vs/hs/de pass through an L-deep shift register.
- Stage 0 (registered): hit = act_y in [Y0, Y0+ITEM_H) and act_x in [X0+k*(ITEM_W+GAP), X0+k*(ITEM_W+GAP)+ITEM_W) for some k. Both ranges are half-open. Register hit, k, lx = act_x - item_left, ly = act_y - Y0.
- Stage 1: rom_addr <= hit ? k*ITEM_H + ly : 0. lx, hit and k are delayed ROM_LAT further.
- Output stage: bit = rom_data[ITEM_W-1-lx].
  - If !de: rgb = 0.
  - Else if !hit: rgb = BG.
  - Else if k==sel_idx and blink_on: rgb = bit ? HL_FG : HL_BG.
  - Else: rgb = bit ? FG : BG.
- Selection FSM, states IDLE, PEND:
  - IDLE: key_left xor key_right stores a direction in pend_dir and moves to PEND.
  - PEND: a further single-direction press overwrites pend_dir (last press wins). At the vs_in rising edge, apply the move and return to IDLE.
  - key_left and key_right in the same cycle: ignored, no state change.
  - Moves wrap: left from 0 goes to N_ITEMS-1; right from N_ITEMS-1 goes to 0.
  - The selection changes only at frame start, so the menu never tears mid-frame.
  - key_ok in any state: sel_confirm pulses the next cycle with the current committed sel_idx. A move pending in the same frame is not included.
- Blink: frame counter increments on each vs_in rising edge. At BLINK_FRAMES-1 it wraps to 0 and toggles blink_on. Any committed move resets the counter to 0 and sets blink_on=1.
- Reset (synchronous, rst=1):
  - sel_idx=0, FSM=IDLE, blink_on=1, frame counter=0, sel_confirm=0.
  - rgb_data=0, vs_out/hs_out/de_out=0, all pipeline registers=0, rom_addr=0.
  - Reset mid-frame discards any pending move; output resumes valid L cycles after release.
- vs edge detection uses a registered copy of vs_in, which is cleared by reset. The first frame after reset does not count a spurious edge.

Decomposition:
- Shared package menu_pkg: RGB565 colour constants, layout defaults (X0, Y0, ITEM_W, ITEM_H, GAP), the L computation function, and the FSM state encoding.
- One natural sub-module, menu_sel_fsm: key handling, pending move, wrap, blink counter, and sel_confirm.
- The pixel pipeline stays in the top level.

Test Plan:
- Reset and latency: rst high 4 cycles, then sweep a 1280x720 frame. All outputs are 0 during reset. de_out equals de_in delayed exactly 3 cycles (ROM_LAT=1).
- Boundaries with a ROM model returning all-ones:
  - Item 0 pixels: x=74 gives BG; x=75 gives glyph; x=314 gives glyph; x=315 gives BG.
  - Item 2 pixels: x=705 gives glyph.
  - Rows: y=347 is in; y=348 gives BG.
  - Addressing: rom_addr for item 1, y=310 is 48+10=58.
- Bit order: ROM word with only bit 239 set at item 0 gives exactly one FG pixel at x=75. With only bit 0 set, the single FG pixel is at x=314.
- Wrap and frame commit: key_left at sel 0 mid-frame leaves sel_idx 0 until the next vs_in rise, then 2. key_right twice from 2 across two frames gives 0, then 1.
- Conflicts: key_left and key_right in the same cycle leave sel_idx unchanged. key_left then key_right in the same frame commits +1. key_ok pulses sel_confirm for 1 cycle with the pre-commit sel_idx.
- Blink with BLINK_FRAMES=2: highlight pixels of the selected item alternate HL and normal colours every 2 frames. A committed move forces highlight on in the next frame.

Source files
------------

// File: rtl/menu_pkg.sv
// Shared menu layout defaults, RGB565 colours, selection FSM encoding and pixel latency.
// Pure declarations; no logic, no latency, no backpressure.
package menu_pkg;

    localparam logic [15:0] RGB_WHITE  = 16'hFFFF;
    localparam logic [15:0] RGB_BLACK  = 16'h0000;
    localparam logic [15:0] RGB_YELLOW = 16'hFFE0;

    localparam int DEF_X0     = 75;
    localparam int DEF_Y0     = 300;
    localparam int DEF_ITEM_W = 240;
    localparam int DEF_ITEM_H = 48;
    localparam int DEF_GAP    = 75;

    typedef enum logic {
        SEL_IDLE = 1'b0,
        SEL_PEND = 1'b1
    } sel_state_e;

    // Stage 0 hit test + stage 1 ROM address, then the ROM's own read latency.
    function automatic int pix_latency(input int rom_lat);
        return 2 + rom_lat;
    endfunction

endpackage

// File: rtl/menu_overlay_if.sv
// Video timing in/out, overlay pixel and glyph ROM port bundle.
// master = timing generator / encoder / ROM side, slave = menu_overlay.
interface menu_overlay_if #(
    parameter int X_BITS = 13,
    parameter int Y_BITS = 13,
    parameter int ADDR_W = 10,
    parameter int ITEM_W = 240
);
    logic [X_BITS-1:0] act_x;
    logic [Y_BITS-1:0] act_y;
    logic              vs_in;
    logic              hs_in;
    logic              de_in;
    logic              vs_out;
    logic              hs_out;
    logic              de_out;
    logic [15:0]       rgb_data;
    logic [ADDR_W-1:0] rom_addr;
    logic [ITEM_W-1:0] rom_data;

    modport master (
        output act_x, act_y, vs_in, hs_in, de_in, rom_data,
        input  vs_out, hs_out, de_out, rgb_data, rom_addr
    );

    modport slave (
        input  act_x, act_y, vs_in, hs_in, de_in, rom_data,
        output vs_out, hs_out, de_out, rgb_data, rom_addr
    );
endinterface

// File: rtl/menu_sel_fsm.sv
// Menu cursor: key presses queue a move that commits on the next vs_in rise; blink timer; confirm pulse.
// sel_confirm one cycle after key_ok; keys are pulses, no backpressure.
module menu_sel_fsm
    import menu_pkg::*;
#(
    parameter int N_ITEMS      = 3,
    parameter int BLINK_FRAMES = 30,
    localparam int SEL_W       = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1
) (
    input  logic             pix_clk,
    input  logic             rst,
    input  logic             vs_in,
    input  logic             key_left,
    input  logic             key_right,
    input  logic             key_ok,
    output logic [SEL_W-1:0] sel_idx,
    output logic             sel_confirm,
    output logic             blink_on
);
    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    sel_state_e       state_q;
    logic             vs_q;
    logic             pend_dir_q;
    logic [SEL_W-1:0] sel_q;
    logic             confirm_q;
    logic             blink_q;
    logic [CNT_W-1:0] frame_cnt_q;

    logic             vs_rise;
    logic             press;
    logic             move_dir;
    logic             commit;
    logic [SEL_W-1:0] sel_next;

    always_comb begin
        vs_rise  = vs_in & ~vs_q;
        press    = key_left ^ key_right;
        // A press landing on the commit cycle is the latest one, so it wins.
        move_dir = press ? key_right : pend_dir_q;
        commit   = vs_rise && (state_q == SEL_PEND);
        sel_next = sel_q;
        if (move_dir) begin
            sel_next = (sel_q == SEL_W'(N_ITEMS - 1)) ? '0 : sel_q + 1'b1;
        end else begin
            sel_next = (sel_q == '0) ? SEL_W'(N_ITEMS - 1) : sel_q - 1'b1;
        end
    end

    always_ff @(posedge pix_clk) begin
        if (rst) begin
            state_q     <= SEL_IDLE;
            vs_q        <= 1'b0;
            pend_dir_q  <= 1'b0;
            sel_q       <= '0;
            confirm_q   <= 1'b0;
            blink_q     <= 1'b1;
            frame_cnt_q <= '0;
        end else begin
            vs_q      <= vs_in;
            confirm_q <= key_ok;
            case (state_q)
                SEL_IDLE: begin
                    if (press) begin
                        pend_dir_q <= key_right;
                        state_q    <= SEL_PEND;
                    end
                end
                SEL_PEND: begin
                    if (vs_rise) begin
                        sel_q   <= sel_next;
                        state_q <= SEL_IDLE;
                    end else if (press) begin
                        pend_dir_q <= key_right;
                    end
                end
                default: state_q <= SEL_IDLE;
            endcase
            if (commit) begin
                frame_cnt_q <= '0;
                blink_q     <= 1'b1;
            end else if (vs_rise) begin
                if (frame_cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
                    frame_cnt_q <= '0;
                    blink_q     <= ~blink_q;
                end else begin
                    frame_cnt_q <= frame_cnt_q + 1'b1;
                end
            end
        end
    end

    assign sel_idx     = sel_q;
    assign sel_confirm = confirm_q;
    assign blink_on    = blink_q;

endmodule

// File: rtl/menu_overlay.sv
// Menu bar renderer: hit test, glyph ROM fetch, colour select; syncs delayed to match.
// Latency 2+ROM_LAT cycles from act_x/act_y/syncs to rgb_data/syncs; streaming, no backpressure.
module menu_overlay
    import menu_pkg::*;
#(
    parameter int          X_BITS       = 13,
    parameter int          Y_BITS       = 13,
    parameter int          N_ITEMS      = 3,
    parameter int          ITEM_W       = DEF_ITEM_W,
    parameter int          ITEM_H       = DEF_ITEM_H,
    parameter int          X0           = DEF_X0,
    parameter int          Y0           = DEF_Y0,
    parameter int          GAP          = DEF_GAP,
    parameter int          ADDR_W       = 10,
    parameter int          ROM_LAT      = 1,
    parameter int          BLINK_FRAMES = 30,
    parameter logic [15:0] FG           = RGB_WHITE,
    parameter logic [15:0] BG           = RGB_BLACK,
    parameter logic [15:0] HL_FG        = RGB_BLACK,
    parameter logic [15:0] HL_BG        = RGB_YELLOW,
    localparam int         SEL_W        = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1
) (
    input  logic             pix_clk,
    input  logic             rst,
    menu_overlay_if.slave    io,
    input  logic             key_left,
    input  logic             key_right,
    input  logic             key_ok,
    output logic [SEL_W-1:0] sel_idx,
    output logic             sel_confirm
);
    localparam int L     = pix_latency(ROM_LAT);
    localparam int PITCH = ITEM_W + GAP;
    localparam int LX_W  = (ITEM_W > 1) ? $clog2(ITEM_W) : 1;
    localparam int LY_W  = (ITEM_H > 1) ? $clog2(ITEM_H) : 1;

    typedef struct packed {
        logic             hit;
        logic [SEL_W-1:0] k;
        logic [LX_W-1:0]  lx;
    } meta_t;

    typedef struct packed {
        logic vs;
        logic hs;
        logic de;
    } sync_t;

    meta_t             meta0_q, meta0_d;
    logic [LY_W-1:0]   ly0_q, ly0_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    meta_t             meta_pipe_q [ROM_LAT+1];
    meta_t             meta_pipe_d [ROM_LAT+1];
    sync_t             sync_pipe_q [L];
    sync_t             sync_pipe_d [L];

    logic [31:0]       x_w;
    logic [31:0]       y_w;
    meta_t             meta_o;
    sync_t             sync_o;
    logic [LX_W-1:0]   rom_bit_idx;
    logic              glyph_bit;
    logic              blink_on;
    logic [15:0]       rgb;

    always_comb begin
        x_w     = {{(32-X_BITS){1'b0}}, io.act_x};
        y_w     = {{(32-Y_BITS){1'b0}}, io.act_y};
        meta0_d = '0;
        ly0_d   = '0;
        if (y_w >= 32'(Y0) && y_w < 32'(Y0 + ITEM_H)) begin
            ly0_d = LY_W'(y_w - 32'(Y0));
            for (int k = 0; k < N_ITEMS; k++) begin
                if (x_w >= 32'(X0 + k * PITCH) && x_w < 32'(X0 + k * PITCH + ITEM_W)) begin
                    meta0_d.hit = 1'b1;
                    meta0_d.k   = SEL_W'(k);
                    meta0_d.lx  = LX_W'(x_w - 32'(X0 + k * PITCH));
                end
            end
        end

        rom_addr_d = meta0_q.hit ? ADDR_W'(32'(meta0_q.k) * 32'(ITEM_H) + 32'(ly0_q)) : '0;

        meta_pipe_d[0] = meta0_q;
        for (int i = 1; i <= ROM_LAT; i++) meta_pipe_d[i] = meta_pipe_q[i-1];

        sync_pipe_d[0] = '{vs: io.vs_in, hs: io.hs_in, de: io.de_in};
        for (int i = 1; i < L; i++) sync_pipe_d[i] = sync_pipe_q[i-1];
    end

    always_ff @(posedge pix_clk) begin
        if (rst) begin
            meta0_q    <= '0;
            ly0_q      <= '0;
            rom_addr_q <= '0;
            for (int i = 0; i <= ROM_LAT; i++) meta_pipe_q[i] <= '0;
            for (int i = 0; i < L; i++) sync_pipe_q[i] <= '0;
        end else begin
            meta0_q     <= meta0_d;
            ly0_q       <= ly0_d;
            rom_addr_q  <= rom_addr_d;
            meta_pipe_q <= meta_pipe_d;
            sync_pipe_q <= sync_pipe_d;
        end
    end

    menu_sel_fsm #(
        .N_ITEMS      (N_ITEMS),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_sel (
        .pix_clk     (pix_clk),
        .rst         (rst),
        .vs_in       (io.vs_in),
        .key_left    (key_left),
        .key_right   (key_right),
        .key_ok      (key_ok),
        .sel_idx     (sel_idx),
        .sel_confirm (sel_confirm),
        .blink_on    (blink_on)
    );

    // The ROM word is consumed straight off its output so the last stage adds no register.
    always_comb begin
        meta_o      = meta_pipe_q[ROM_LAT];
        sync_o      = sync_pipe_q[L-1];
        rom_bit_idx = LX_W'(ITEM_W - 1) - meta_o.lx;
        glyph_bit   = io.rom_data[rom_bit_idx];
        rgb         = '0;
        if (!sync_o.de) begin
            rgb = '0;
        end else if (!meta_o.hit) begin
            rgb = BG;
        end else if (meta_o.k == sel_idx && blink_on) begin
            rgb = glyph_bit ? HL_FG : HL_BG;
        end else begin
            rgb = glyph_bit ? FG : BG;
        end
    end

    assign io.rgb_data = rgb;
    assign io.rom_addr = rom_addr_q;
    assign io.vs_out   = sync_o.vs;
    assign io.hs_out   = sync_o.hs;
    assign io.de_out   = sync_o.de;

endmodule

// File: tb/tb_menu_overlay.sv
// Randomized bench for menu_overlay against a frame-level reference model.
module tb_menu_overlay;
    import menu_pkg::*;

    localparam int N      = 3;
    localparam int IW     = 240;
    localparam int IH     = 48;
    localparam int X0     = 75;
    localparam int Y0     = 300;
    localparam int GAP    = 75;
    localparam int BF     = 2;
    localparam int NFRM   = 30;
    localparam int BURST  = 200;
    localparam logic [15:0] C_FG    = 16'hFFFF;
    localparam logic [15:0] C_BG    = 16'h0000;
    localparam logic [15:0] C_HL_FG = 16'h0000;
    localparam logic [15:0] C_HL_BG = 16'hFFE0;

    typedef struct {
        bit vs;
        bit hs;
        bit de;
        int x;
        int y;
    } pix_t;

    logic       pix_clk = 1'b0;
    logic       rst;
    logic       key_left, key_right, key_ok;
    logic [1:0] sel_idx;
    logic       sel_confirm;

    int n_checks = 0;
    int n_errors = 0;
    int rom_mode = 0;

    int m_sel, m_cnt;
    bit m_pend, m_dir, m_blink, m_vs_prev, m_conf;
    pix_t h0, h1, h2;
    pix_t zero_pix = '{vs: 1'b0, hs: 1'b0, de: 1'b0, x: 0, y: 0};

    menu_overlay_if #(.X_BITS(13), .Y_BITS(13), .ADDR_W(10), .ITEM_W(IW)) vif ();

    menu_overlay #(.BLINK_FRAMES(BF)) dut (
        .pix_clk     (pix_clk),
        .rst         (rst),
        .io          (vif),
        .key_left    (key_left),
        .key_right   (key_right),
        .key_ok      (key_ok),
        .sel_idx     (sel_idx),
        .sel_confirm (sel_confirm)
    );

    always #5 pix_clk = ~pix_clk;

    function automatic logic [IW-1:0] rom_word(input int addr, input int mode);
        logic [IW-1:0] w;
        w = '0;
        case (mode)
            0: w = '1;
            1: w[IW-1] = 1'b1;
            2: w[0] = 1'b1;
            default: for (int i = 0; i < IW; i++) w[i] = (((i * 7 + addr * 13) % 5) < 2);
        endcase
        return w;
    endfunction

    always @(posedge pix_clk) vif.rom_data <= rom_word(int'(vif.rom_addr), rom_mode);

    // Which item (if any) a screen pixel lands in, from the layout arithmetic.
    function automatic bit locate(input pix_t p, output int k, output int lx, output int ly);
        int off;
        k = 0; lx = 0; ly = 0;
        if (p.y < Y0 || p.y >= Y0 + IH || p.x < X0) return 1'b0;
        off = p.x - X0;
        k   = off / (IW + GAP);
        lx  = off % (IW + GAP);
        ly  = p.y - Y0;
        return (k < N) && (lx < IW);
    endfunction

    function automatic logic [31:0] exp_addr(input pix_t p);
        int k, lx, ly;
        if (!locate(p, k, lx, ly)) return 0;
        return 32'(k * IH + ly);
    endfunction

    function automatic logic [15:0] exp_rgb(input pix_t p);
        int k, lx, ly;
        logic [IW-1:0] w;
        bit b;
        if (!p.de) return 16'h0;
        if (!locate(p, k, lx, ly)) return C_BG;
        w = rom_word(k * IH + ly, rom_mode);
        b = w[IW-1-lx];
        if (k == m_sel && m_blink) return b ? C_HL_FG : C_HL_BG;
        return b ? C_FG : C_BG;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_sel = 0; m_cnt = 0; m_pend = 0; m_dir = 0;
        m_blink = 1; m_vs_prev = 0; m_conf = 0;
    endtask

    task automatic model_update(input bit vs, input bit kl, input bit kr, input bit ko);
        bit rise, single, dir, committed;
        rise      = vs && !m_vs_prev;
        m_vs_prev = vs;
        single    = kl ^ kr;
        m_conf    = ko;
        committed = 0;
        if (m_pend && rise) begin
            dir       = single ? kr : m_dir;
            m_sel     = dir ? (m_sel + 1) % N : (m_sel + N - 1) % N;
            m_pend    = 0;
            committed = 1;
        end else if (single) begin
            m_pend = 1;
            m_dir  = kr;
        end
        if (committed) begin
            m_cnt = 0; m_blink = 1;
        end else if (rise) begin
            if (m_cnt == BF - 1) begin
                m_cnt = 0; m_blink = !m_blink;
            end else begin
                m_cnt++;
            end
        end
    endtask

    task automatic step(input bit r, input bit vs, input bit hs, input bit de,
                        input int x, input int y, input bit kl, input bit kr, input bit ko);
        pix_t cur;
        @(negedge pix_clk);
        rst = r; vif.vs_in = vs; vif.hs_in = hs; vif.de_in = de;
        vif.act_x = 13'(x); vif.act_y = 13'(y);
        key_left = kl; key_right = kr; key_ok = ko;
        @(posedge pix_clk);
        cur = '{vs: vs, hs: hs, de: de, x: x, y: y};
        if (r) begin
            model_reset();
            h0 = zero_pix; h1 = zero_pix; h2 = zero_pix;
        end else begin
            h2 = h1; h1 = h0; h0 = cur;
            model_update(vs, kl, kr, ko);
        end
        #1;
        check_eq("de_out", 32'(vif.de_out), 32'(h2.de));
        check_eq("vs_out", 32'(vif.vs_out), 32'(h2.vs));
        check_eq("hs_out", 32'(vif.hs_out), 32'(h2.hs));
        check_eq("rgb_data", 32'(vif.rgb_data), 32'(exp_rgb(h2)));
        check_eq("rom_addr", 32'(vif.rom_addr), exp_addr(h1));
        check_eq("sel_idx", 32'(sel_idx), 32'(m_sel));
        check_eq("sel_confirm", 32'(sel_confirm), 32'(m_conf));
    endtask

    int dir_x [9] = '{74, 75, 314, 315, 705, 400, 75, 75, 76};
    int dir_y [9] = '{300, 300, 300, 300, 300, 310, 347, 348, 299};
    int edge_x [12] = '{74, 75, 314, 315, 389, 390, 629, 630, 704, 705, 944, 945};
    int edge_y [5] = '{299, 300, 310, 347, 348};
    // Per-frame key script: 0 none, 1 left, 2 right, 3 both, 4 left then right, 5 ok.
    int sched [8] = '{0, 1, 2, 2, 3, 4, 5, 0};

    initial begin
        int x, y, r;
        bit de, kl, kr, ko, rs;
        rst = 1'b1; key_left = 0; key_right = 0; key_ok = 0;
        vif.vs_in = 0; vif.hs_in = 0; vif.de_in = 0; vif.act_x = '0; vif.act_y = '0;
        model_reset();
        h0 = zero_pix; h1 = zero_pix; h2 = zero_pix;
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int f = 0; f < NFRM; f++) begin
            rom_mode = f % 4;
            for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0, 0, 0, 0);
            for (int i = 0; i < 2; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
            for (int i = 0; i < BURST; i++) begin
                kl = 0; kr = 0; ko = 0; rs = 0; de = 1;
                if (i < 9) begin
                    x = dir_x[i]; y = dir_y[i];
                end else begin
                    r = $urandom_range(0, 2);
                    x = (r == 0) ? $urandom_range(0, 1279)
                                 : edge_x[$urandom_range(0, 11)] + $urandom_range(0, 2) - 1;
                    r = $urandom_range(0, 2);
                    y = (r == 0) ? $urandom_range(0, 719)
                      : (r == 1) ? edge_y[$urandom_range(0, 4)] : $urandom_range(290, 360);
                    de = ($urandom_range(0, 9) != 0);
                end
                if (f < 8) begin
                    if (i == 20) begin
                        case (sched[f])
                            1, 4: kl = 1;
                            2: kr = 1;
                            3: begin kl = 1; kr = 1; end
                            5: ko = 1;
                            default: ;
                        endcase
                    end
                    if (i == 40 && sched[f] == 4) kr = 1;
                end else if (i > 10) begin
                    r  = $urandom_range(0, 99);
                    kl = (r < 3) || (r >= 6 && r < 8);
                    kr = (r >= 3 && r < 8);
                    ko = (r >= 8 && r < 10);
                end
                if (f == 25) begin
                    if (i == 30) begin kl = 1; kr = 0; end
                    rs = (i >= 60 && i < 63);
                end
                step(rs, 0, $urandom_range(0, 1), de, x, y, kl, kr, ko);
            end
        end
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
